// File: rtl/conv_addr_ctrl.sv
// Address/control sequencer for a 2-D "valid" convolution: walks each output
// pixel, issues K*K image/filter reads, strobes the MAC and writes the result.
module conv_addr_ctrl #(
    parameter int unsigned IMG_N = 8,
    parameter int unsigned FLT_K = 3,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] x,
    input  logic [AW-1:0] y,
    input  logic [AW-1:0] z,
    output logic [AW-1:0] img_addr,
    output logic [AW-1:0] flt_addr,
    output logic          rd_en,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          done
);

    localparam int unsigned OUT = IMG_N - FLT_K + 1;
    localparam int unsigned OW  = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int unsigned KW  = (FLT_K > 1) ? $clog2(FLT_K) : 1;
    localparam logic [OW-1:0] O_LAST = OW'(OUT - 1);
    localparam logic [KW-1:0] K_LAST = KW'(FLT_K - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [OW-1:0] r_q, r_d, c_q, c_d;
    logic [KW-1:0] i_q, i_d, j_q, j_d;

    logic [AW-1:0] img_addr_q, img_addr_d;
    logic [AW-1:0] flt_addr_q, flt_addr_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          rd_en_q, rd_en_d;
    logic          mac_clr_q, mac_clr_d;
    logic          mac_en_q, mac_en_d;
    logic          wr_en_q, wr_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // State, base and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            r_q     <= r_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                x_d     = x;
                y_d     = y;
                z_d     = z;
                r_d     = '0;
                c_d     = '0;
                i_d     = '0;
                j_d     = '0;
                state_d = S_CLR;
            end
            S_CLR: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                if (j_q == K_LAST) begin
                    j_d = '0;
                    if (i_q == K_LAST) begin
                        i_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        i_d = i_q + KW'(1);
                    end
                end else begin
                    j_d = j_q + KW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (c_q == O_LAST) begin
                    c_d = '0;
                    if (r_q == O_LAST) begin
                        r_d     = '0;
                        state_d = S_FIN;
                    end else begin
                        r_d     = r_q + OW'(1);
                        state_d = S_CLR;
                    end
                end else begin
                    c_d     = c_q + OW'(1);
                    state_d = S_CLR;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the upcoming state so they line up with it once registered
    always_comb begin
        rd_en_d    = (state_d == S_MAC);
        mac_clr_d  = (state_d == S_CLR);
        wr_en_d    = (state_d == S_WRITE);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
        mac_en_d   = rd_en_q;
        img_addr_d = '0;
        flt_addr_d = '0;
        wr_addr_d  = '0;

        if (rd_en_d) begin
            img_addr_d = x_q + AW'((32'(r_d) + 32'(i_d)) * IMG_N + 32'(c_d) + 32'(j_d));
            flt_addr_d = y_q + AW'(32'(i_d) * FLT_K + 32'(j_d));
        end
        if (wr_en_d) begin
            wr_addr_d = z_q + AW'(32'(r_d) * OUT + 32'(c_d));
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_addr_q <= '0;
            flt_addr_q <= '0;
            wr_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            img_addr_q <= img_addr_d;
            flt_addr_q <= flt_addr_d;
            wr_addr_q  <= wr_addr_d;
            rd_en_q    <= rd_en_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign img_addr = img_addr_q;
    assign flt_addr = flt_addr_q;
    assign wr_addr  = wr_addr_q;
    assign rd_en    = rd_en_q;
    assign mac_clr  = mac_clr_q;
    assign mac_en   = mac_en_q;
    assign wr_en    = wr_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
